// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: two-requester round-robin front end for a UART transmitter.
// Generates the baud tick, accepts one byte at a time, holds tx_en_o until
// the transmitter picks the byte up on a tick, then waits for t_done_i.
// Optional feature macro: UART_TX_TIMEOUT_EN adds a WAIT_DONE watchdog that
// sets the sticky timeout_err_o after TO_TICKS baud ticks without t_done_i.
//
// state     | meaning
// IDLE      | arbitrate requesters, accept at most one byte
// LOAD      | tx_en_o high with the latched byte, waiting for a baud tick
// WAIT_DONE | frame in flight, waiting for t_done_i (or watchdog expiry)
module uart_tx_ctrl #(
   parameter int DIV_W    = 16,
   parameter int TO_TICKS = 12
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [DIV_W-1:0] baud_div_i,
   input  logic             req0_valid_i,
   input  logic [7:0]       req0_data_i,
   output logic             req0_ready_o,
   input  logic             req1_valid_i,
   input  logic [7:0]       req1_data_i,
   output logic             req1_ready_o,
   output logic             tx_tick_o,
   output logic             tx_en_o,
   output logic [7:0]       tx_data_o,
   input  logic             t_done_i,
   output logic             busy_o,
   output logic             grant_o,
   output logic             timeout_err_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [DIV_W-1:0] tick_cnt;
   logic             accept;
   logic             sel;
   logic             timeout_hit;

   // Free-running baud tick: counts 0..baud_div_i, registered pulse at the top.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         tick_cnt  <= '0;
         tx_tick_o <= 1'b0;
      end else if (tick_cnt >= baud_div_i) begin
         tick_cnt  <= '0;
         tx_tick_o <= 1'b1;
      end else begin
         tick_cnt  <= tick_cnt + DIV_W'(1);
         tx_tick_o <= 1'b0;
      end
   end

`ifdef UART_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_TICKS + 1);

   logic [TO_W-1:0] to_cnt;

   // Watchdog down-counter: armed while in LOAD, decremented per tick in WAIT_DONE.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         to_cnt        <= '0;
         timeout_err_o <= 1'b0;
      end else begin
         if (state == LOAD) begin
            to_cnt <= TO_W'(TO_TICKS);
         end else if ((state == WAIT_DONE) && tx_tick_o && (to_cnt != '0)) begin
            to_cnt <= to_cnt - TO_W'(1);
         end
         if (timeout_hit) begin
            timeout_err_o <= 1'b1;
         end
      end
   end

   // A real completion on the same cycle as expiry wins over the timeout.
   assign timeout_hit = (state == WAIT_DONE) && !t_done_i && tx_tick_o &&
                        (to_cnt == TO_W'(1));
`else
   logic unused_to_ticks;

   assign unused_to_ticks = (TO_TICKS != 0);
   assign timeout_hit     = 1'b0;
   assign timeout_err_o   = 1'b0;
`endif

   // State register plus byte/grant capture on acceptance.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         tx_data_o <= 8'h00;
         grant_o   <= 1'b1;
      end else begin
         state <= state_nxt;
         if (accept) begin
            tx_data_o <= sel ? req1_data_i : req0_data_i;
            grant_o   <= sel;
         end
      end
   end

   // Next-state and arbitration; acceptance is suppressed during reset.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      sel       = 1'b0;
      case (state)
         IDLE: begin
            if (rst_i && (req0_valid_i || req1_valid_i)) begin
               accept    = 1'b1;
               state_nxt = LOAD;
               if (req0_valid_i && req1_valid_i) begin
                  sel = ~grant_o;
               end else begin
                  sel = req1_valid_i;
               end
            end
         end
         LOAD: begin
            if (tx_tick_o) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (t_done_i || timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req0_ready_o = accept & ~sel;
   assign req1_ready_o = accept & sel;
   assign tx_en_o      = (state == LOAD);
   assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: scoreboard of expected (byte, requester)
// pairs, a small transmitter model answering with t_done_i, one task per scenario.
module tb_uart_tx_ctrl;

   localparam int DIV_W    = 16;
   localparam int TO_TICKS = 12;

   typedef struct packed {
      logic [7:0] data;
      logic       idx;
   } exp_t;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [DIV_W-1:0] baud_div_i;
   logic             req0_valid_i;
   logic [7:0]       req0_data_i;
   logic             req0_ready_o;
   logic             req1_valid_i;
   logic [7:0]       req1_data_i;
   logic             req1_ready_o;
   logic             tx_tick_o;
   logic             tx_en_o;
   logic [7:0]       tx_data_o;
   logic             t_done_i;
   logic             busy_o;
   logic             grant_o;
   logic             timeout_err_o;

   int         n_chk  = 0;
   int         n_fail = 0;
   exp_t       sb_q[$];
   logic [7:0] exp_data;
   logic       m_grant;

   uart_tx_ctrl #(
      .DIV_W    (DIV_W),
      .TO_TICKS (TO_TICKS)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .baud_div_i    (baud_div_i),
      .req0_valid_i  (req0_valid_i),
      .req0_data_i   (req0_data_i),
      .req0_ready_o  (req0_ready_o),
      .req1_valid_i  (req1_valid_i),
      .req1_data_i   (req1_data_i),
      .req1_ready_o  (req1_ready_o),
      .tx_tick_o     (tx_tick_o),
      .tx_en_o       (tx_en_o),
      .tx_data_o     (tx_data_o),
      .t_done_i      (t_done_i),
      .busy_o        (busy_o),
      .grant_o       (grant_o),
      .timeout_err_o (timeout_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Round-robin model: with both requesters valid, serve the one not granted last.
   task automatic push_rr(input int n, input logic [7:0] d0, input logic [7:0] d1);
      logic s;
      for (int k = 0; k < n; k++) begin
         s = ~m_grant;
         sb_q.push_back('{data: (s ? d1 : d0), idx: s});
         m_grant = s;
      end
   endtask

   // Entry at posedge+1 with this cycle's inputs driven. Samples at +2, drives at +1.
   task automatic run_frames(input int n_frames, input int done_delay,
                             input bit hold, input bit noise);
      int   served     = 0;
      int   budget     = 0;
      int   phase      = 0;
      int   done_cd    = -1;
      bit   fin        = 1'b0;
      bit   last_quiet = 1'b1;
      bit   drop0      = 1'b0;
      bit   drop1      = 1'b0;
      bit   chk_grant  = 1'b0;
      logic exp_g      = 1'b0;
      exp_t e;
      while (!fin) begin
         #1;
         n_chk++;
         if (tx_data_o !== exp_data) begin
            n_fail++;
            $display("FAIL data_hold: tx_data_o=%h expected %h at %0t", tx_data_o, exp_data, $time);
         end
         if (chk_grant) begin
            n_chk++;
            if (grant_o !== exp_g) begin
               n_fail++;
               $display("FAIL grant: grant_o=%b expected %b at %0t", grant_o, exp_g, $time);
            end
            chk_grant = 1'b0;
         end
         case (phase)
            1: begin
               n_chk++;
               if (tx_en_o !== 1'b1 || busy_o !== 1'b1) begin
                  n_fail++;
                  $display("FAIL load_phase: tx_en_o=%b busy_o=%b expected 1 1 at %0t", tx_en_o, busy_o, $time);
               end
               if (tx_tick_o) begin
                  phase   = 2;
                  done_cd = done_delay;
               end
            end
            2: begin
               n_chk++;
               if (tx_en_o !== 1'b0 || busy_o !== 1'b1) begin
                  n_fail++;
                  $display("FAIL wait_phase: tx_en_o=%b busy_o=%b expected 0 1 at %0t", tx_en_o, busy_o, $time);
               end
               if (t_done_i) phase = 3;
            end
            3: begin
               n_chk++;
               if (busy_o !== 1'b0) begin
                  n_fail++;
                  $display("FAIL busy_fall: busy_o=%b expected 0 at %0t", busy_o, $time);
               end
               served++;
               phase = 0;
            end
            default: ;
         endcase
         if (served >= n_frames) begin
            fin          = 1'b1;
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
            t_done_i     = 1'b0;
         end else begin
            if (req0_ready_o || req1_ready_o) begin
               n_chk++;
               if ((req0_ready_o && req1_ready_o) || phase != 0 || sb_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL ready_ok: ready0=%b ready1=%b phase=%0d queued=%0d expected one ready in idle with a queued entry",
                           req0_ready_o, req1_ready_o, phase, sb_q.size());
               end else begin
                  e = sb_q.pop_front();
                  n_chk++;
                  if (req1_ready_o !== e.idx) begin
                     n_fail++;
                     $display("FAIL arb_order: served req%0d expected req%0d at %0t", req1_ready_o, e.idx, $time);
                  end
                  exp_data  = e.data;
                  exp_g     = e.idx;
                  chk_grant = 1'b1;
                  phase     = 1;
                  if (!hold) begin
                     drop0 = req0_ready_o;
                     drop1 = req1_ready_o;
                  end
               end
            end
            last_quiet = (phase != 2);
            budget++;
            if (budget > 100 * n_frames) begin
               n_chk++;
               n_fail++;
               $display("FAIL frame_timeout: served %0d frames expected %0d", served, n_frames);
               fin          = 1'b1;
               req0_valid_i = 1'b0;
               req1_valid_i = 1'b0;
               t_done_i     = 1'b0;
            end else begin
               @(posedge clk_i); #1;
               t_done_i = (done_cd == 0) || (noise && last_quiet);
               if (done_cd >= 0) done_cd--;
               if (drop0) req0_valid_i = 1'b0;
               if (drop1) req1_valid_i = 1'b0;
               drop0 = 1'b0;
               drop1 = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clk_i); #2;
      n_chk++;
      if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready: ready0=%b ready1=%b expected 0 0", req0_ready_o, req1_ready_o);
      end
      n_chk++;
      if (tx_tick_o !== 1'b0 || tx_en_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ctl: tick=%b en=%b busy=%b expected 0 0 0", tx_tick_o, tx_en_o, busy_o);
      end
      n_chk++;
      if (tx_data_o !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_data: tx_data_o=%h expected 00", tx_data_o);
      end
      n_chk++;
      if (grant_o !== 1'b1 || timeout_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_grant_err: grant=%b err=%b expected 1 0", grant_o, timeout_err_o);
      end
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i    = 1'b1;
      exp_data = 8'h00;
      m_grant  = 1'b1;
   endtask

   // Entry right after reset release with baud_div_i=3: first tick four cycles later.
   task automatic test_tick();
      for (int k = 0; k < 16; k++) begin
         #1;
         n_chk++;
         if (tx_tick_o !== ((k != 0) && (k % 4 == 0)) || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_div3: k=%0d tick=%b busy=%b expected %b 0", k, tx_tick_o, busy_o,
                     ((k != 0) && (k % 4 == 0)));
         end
         @(posedge clk_i); #1;
      end
      baud_div_i = '0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #2;
         n_chk++;
         if (tx_tick_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_div0: k=%0d tick=%b expected 1", k, tx_tick_o);
         end
      end
   endtask

   task automatic test_single();
      @(posedge clk_i); #1;
      baud_div_i = 3;
      sb_q.push_back('{data: 8'hA5, idx: 1'b0});
      m_grant      = 1'b0;
      req0_data_i  = 8'hA5;
      req0_valid_i = 1'b1;
      run_frames(1, 2, 1'b0, 1'b0);
   endtask

   task automatic test_round_robin();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i        = 1'b1;
      exp_data     = 8'h00;
      m_grant      = 1'b1;
      baud_div_i   = 2;
      req0_data_i  = 8'h11;
      req1_data_i  = 8'h22;
      req0_valid_i = 1'b1;
      req1_valid_i = 1'b1;
      push_rr(4, 8'h11, 8'h22);
      run_frames(4, 1, 1'b1, 1'b0);
   endtask

   task automatic test_done_ignored();
      @(posedge clk_i); #1;
      baud_div_i = 5;
      sb_q.push_back('{data: 8'h5A, idx: 1'b1});
      m_grant      = 1'b1;
      req1_data_i  = 8'h5A;
      req1_valid_i = 1'b1;
      t_done_i     = 1'b1;
      run_frames(1, 1, 1'b0, 1'b1);
   endtask

   task automatic test_timeout();
      int ticks = 0;
      bit got   = 1'b0;
      @(posedge clk_i); #1;
      baud_div_i   = 1;
      req0_data_i  = 8'h3C;
      req0_valid_i = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         #1;
         if (req0_ready_o) got = 1'b1;
         @(posedge clk_i); #1;
      end
      req0_valid_i = 1'b0;
      exp_data     = 8'h3C;
      m_grant      = 1'b0;
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL to_accept: ready0 never seen, expected within 10 cycles");
      end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         #1;
         if (tx_en_o && tx_tick_o) got = 1'b1;
         @(posedge clk_i); #1;
      end
      n_chk++;
      if (!got || tx_data_o !== 8'h3C) begin
         n_fail++;
         $display("FAIL to_load: load tick seen=%b tx_data_o=%h expected 1 3c", got, tx_data_o);
      end
      for (int i = 0; i < 100 && ticks < TO_TICKS; i++) begin
         #1;
         n_chk++;
         if (busy_o !== 1'b1 || tx_en_o !== 1'b0 || timeout_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: tick#%0d busy=%b en=%b err=%b expected 1 0 0", ticks, busy_o, tx_en_o, timeout_err_o);
         end
         if (tx_tick_o) ticks++;
         @(posedge clk_i); #1;
      end
      #1;
      n_chk++;
`ifdef UART_TX_TIMEOUT_EN
      if (ticks != TO_TICKS || busy_o !== 1'b0 || timeout_err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL to_expire: ticks=%0d busy=%b err=%b expected %0d 0 1", ticks, busy_o, timeout_err_o, TO_TICKS);
      end
      @(posedge clk_i); #2;
      n_chk++;
      if (timeout_err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL to_sticky: err=%b expected 1", timeout_err_o);
      end
`else
      if (ticks != TO_TICKS || busy_o !== 1'b1 || timeout_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL to_hold: ticks=%0d busy=%b err=%b expected %0d 1 0", ticks, busy_o, timeout_err_o, TO_TICKS);
      end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #2;
         n_chk++;
         if (busy_o !== 1'b1 || timeout_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_hold_long: busy=%b err=%b expected 1 0", busy_o, timeout_err_o);
         end
      end
      @(posedge clk_i); #1;
      t_done_i = 1'b1;
      @(posedge clk_i); #1;
      t_done_i = 1'b0;
      #1;
      n_chk++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL to_release: busy=%b expected 0", busy_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      bit got = 1'b0;
      @(posedge clk_i); #1;
      baud_div_i   = 1;
      req0_data_i  = 8'h77;
      req1_data_i  = 8'h88;
      req0_valid_i = 1'b1;
      req1_valid_i = 1'b1;
      for (int i = 0; i < 30 && !got; i++) begin
         #1;
         if (busy_o && !tx_en_o) got = 1'b1;
         else begin
            @(posedge clk_i); #1;
         end
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL mid_reach_wait: WAIT_DONE not reached within 30 cycles");
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #2;
      n_chk++;
      if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_ready: ready0=%b ready1=%b expected 0 0", req0_ready_o, req1_ready_o);
      end
      n_chk++;
      if (tx_tick_o !== 1'b0 || tx_en_o !== 1'b0 || busy_o !== 1'b0 || tx_data_o !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_outputs: tick=%b en=%b busy=%b data=%h expected 0 0 0 00",
                  tx_tick_o, tx_en_o, busy_o, tx_data_o);
      end
      n_chk++;
      if (grant_o !== 1'b1 || timeout_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_grant_err: grant=%b err=%b expected 1 0", grant_o, timeout_err_o);
      end
      @(posedge clk_i); #1;
      rst_i    = 1'b1;
      exp_data = 8'h00;
      m_grant  = 1'b1;
      push_rr(1, 8'h77, 8'h88);
      run_frames(1, 0, 1'b1, 1'b0);
   endtask

   initial begin
      rst_i        = 1'b0;
      baud_div_i   = 3;
      req0_valid_i = 1'b1;
      req0_data_i  = 8'hEE;
      req1_valid_i = 1'b1;
      req1_data_i  = 8'hDD;
      t_done_i     = 1'b0;
      exp_data     = 8'h00;
      m_grant      = 1'b1;
      test_reset();
      test_tick();
      test_single();
      test_round_robin();
      test_done_ignored();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
